// File: rtl/jt51_timer_ab_pkg.sv
// Shared constants for the jt51 Timer A / Timer B stage: default widths and
// the position of each timer flag inside the CPU status byte.
package jt51_timer_ab_pkg;

    localparam int CW_A_DEF  = 10;  // Timer A counter width
    localparam int CW_B_DEF  = 8;   // Timer B counter width
    localparam int PRE_B_DEF = 4;   // Timer B ticks once per 2^PRE_B samples
    localparam int PRE_A_DEF = 0;   // Timer A has no prescaler

    localparam int NUM_FLAGS  = 2;
    localparam int FLAG_BIT_A = 0;  // status byte bit for flag_A
    localparam int FLAG_BIT_B = 1;  // status byte bit for flag_B

    // Place both flags at their status-byte positions.
    function automatic logic [NUM_FLAGS-1:0] pack_flags(input logic fa, input logic fb);
        logic [NUM_FLAGS-1:0] v;
        v             = {NUM_FLAGS{1'b0}};
        v[FLAG_BIT_A] = fa;
        v[FLAG_BIT_B] = fb;
        return v;
    endfunction

endpackage

// File: rtl/jt51_timer_ab_timer.sv
// Generic reload timer: counts sample ticks while load is high, reloads the
// start value on a load rising edge or on overflow past all-ones, and keeps a
// sticky status flag. An optional prescaler divides the sample tick by
// 2^PRE_W; PRE_W = 0 bypasses it.
module jt51_timer #(
    parameter int CW    = 10,
    parameter int PRE_W = 0
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clk_en_i,
    input  logic          zero_i,
    input  logic          load_i,
    input  logic [CW-1:0] start_i,
    input  logic          enable_irq_i,
    input  logic          clr_flag_i,
    output logic          flag_o,
    output logic          flag_d_o,
    output logic          overflow_o
);

    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic          load_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          flag_q, flag_d;
    logic          ovf_q, ovf_d;
    logic          load_edge_s;
    logic          run_zero_s;
    logic          tick_s;
    logic          set_flag_s;

    // A load edge wins over a simultaneous zero: that cycle only reloads.
    assign load_edge_s = load_i & ~load_q;
    assign run_zero_s  = load_i & zero_i & ~load_edge_s;

    generate
        if (PRE_W > 0) begin : g_pre
            localparam logic [PRE_W-1:0] PRE_MAX = {PRE_W{1'b1}};
            localparam logic [PRE_W-1:0] PRE_ONE = PRE_W'(1);
            logic [PRE_W-1:0] pre_q, pre_d;

            assign tick_s = (pre_q == PRE_MAX);

            // Prescaler next state: cleared on load edge, advanced per running zero.
            always_comb begin
                pre_d = pre_q;
                if (load_edge_s) begin
                    pre_d = {PRE_W{1'b0}};
                end else if (run_zero_s) begin
                    pre_d = pre_q + PRE_ONE;
                end else begin
                    pre_d = pre_q;
                end
            end

            // Prescaler register.
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    pre_q <= {PRE_W{1'b0}};
                end else if (clk_en_i) begin
                    pre_q <= pre_d;
                end
            end
        end else begin : g_nopre
            assign tick_s = 1'b1;
        end
    endgenerate

    // Counter, overflow pulse and flag next state.
    always_comb begin
        cnt_d      = cnt_q;
        ovf_d      = 1'b0;
        set_flag_s = 1'b0;
        if (load_edge_s) begin
            cnt_d = start_i;
        end else if (run_zero_s && tick_s) begin
            if (cnt_q == CNT_MAX) begin
                cnt_d      = start_i;
                ovf_d      = 1'b1;
                set_flag_s = enable_irq_i;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else begin
            cnt_d = cnt_q;
        end

        // A set landing together with a clear must leave the flag high.
        if (set_flag_s) begin
            flag_d = 1'b1;
        end else if (clr_flag_i) begin
            flag_d = 1'b0;
        end else begin
            flag_d = flag_q;
        end
    end

    // Timer state registers; everything freezes while clk_en is low.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            load_q <= 1'b0;
            cnt_q  <= {CW{1'b0}};
            flag_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (clk_en_i) begin
            load_q <= load_i;
            cnt_q  <= cnt_d;
            flag_q <= flag_d;
            ovf_q  <= ovf_d;
        end
    end

    assign flag_o     = flag_q;
    assign flag_d_o   = flag_d;
    assign overflow_o = ovf_q;

endmodule

// File: rtl/jt51_timer_ab.sv
// jt51 Timer A (10-bit, no prescaler) and Timer B (8-bit, /16 prescaler).
// Exposes both status flags, the Timer A overflow pulse used for CSM key-on,
// and a registered active-low interrupt that always equals ~(flag_A|flag_B).
module jt51_timer_ab
    import jt51_timer_ab_pkg::*;
#(
    parameter int CW_A  = CW_A_DEF,
    parameter int CW_B  = CW_B_DEF,
    parameter int PRE_B = PRE_B_DEF
) (
    input  logic            rst,
    input  logic            clk,
    input  logic            clk_en,
    input  logic            zero,
    input  logic [CW_A-1:0] value_A,
    input  logic [CW_B-1:0] value_B,
    input  logic            load_A,
    input  logic            load_B,
    input  logic            enable_irq_A,
    input  logic            enable_irq_B,
    input  logic            clr_flag_A,
    input  logic            clr_flag_B,
    output logic            flag_A,
    output logic            flag_B,
    output logic            overflow_A,
    output logic            irq_n
);

    logic                 flag_a_d_s;
    logic                 flag_b_d_s;
    logic                 ovf_b_unused_s;
    logic [NUM_FLAGS-1:0] flags_d_s;
    logic                 irq_n_q;

    jt51_timer #(
        .CW    (CW_A),
        .PRE_W (PRE_A_DEF)
    ) u_timer_a (
        .clk_i        (clk),
        .rst_i        (rst),
        .clk_en_i     (clk_en),
        .zero_i       (zero),
        .load_i       (load_A),
        .start_i      (value_A),
        .enable_irq_i (enable_irq_A),
        .clr_flag_i   (clr_flag_A),
        .flag_o       (flag_A),
        .flag_d_o     (flag_a_d_s),
        .overflow_o   (overflow_A)
    );

    jt51_timer #(
        .CW    (CW_B),
        .PRE_W (PRE_B)
    ) u_timer_b (
        .clk_i        (clk),
        .rst_i        (rst),
        .clk_en_i     (clk_en),
        .zero_i       (zero),
        .load_i       (load_B),
        .start_i      (value_B),
        .enable_irq_i (enable_irq_B),
        .clr_flag_i   (clr_flag_B),
        .flag_o       (flag_B),
        .flag_d_o     (flag_b_d_s),
        .overflow_o   (ovf_b_unused_s)
    );

    // Interrupt is built from the flags' next state so it tracks them exactly.
    assign flags_d_s = pack_flags(flag_a_d_s, flag_b_d_s);

    // Registered active-low interrupt line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_n_q <= 1'b1;
        end else if (clk_en) begin
            irq_n_q <= ~(|flags_d_s);
        end
    end

    assign irq_n = irq_n_q;

endmodule

// File: tb/tb_jt51_timer_ab.sv
// Scoreboard bench for jt51_timer_ab: stimulus advances a behavioural model
// each clock and queues the expected outputs; a monitor on the falling edge
// pops and compares.
module tb_jt51_timer_ab;

    localparam int A_MAX   = 1023;
    localparam int B_MAX   = 255;
    localparam int B_DIV   = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clk_en = 1'b0;
    logic       zero = 1'b0;
    logic [9:0] value_A = 10'd0;
    logic [7:0] value_B = 8'd0;
    logic       load_A = 1'b0;
    logic       load_B = 1'b0;
    logic       enable_irq_A = 1'b0;
    logic       enable_irq_B = 1'b0;
    logic       clr_flag_A = 1'b0;
    logic       clr_flag_B = 1'b0;
    logic       flag_A, flag_B, overflow_A, irq_n;

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_q[$];

    // reference model state (spec-level quantities)
    int   m_cnt_a, m_cnt_b, m_zeros_b;
    logic m_prev_a, m_prev_b;
    logic m_flag_a, m_flag_b, m_ovf_a, m_irqn;

    always #5 clk = ~clk;

    jt51_timer_ab dut (
        .rst          (rst),
        .clk          (clk),
        .clk_en       (clk_en),
        .zero         (zero),
        .value_A      (value_A),
        .value_B      (value_B),
        .load_A       (load_A),
        .load_B       (load_B),
        .enable_irq_A (enable_irq_A),
        .enable_irq_B (enable_irq_B),
        .clr_flag_A   (clr_flag_A),
        .clr_flag_B   (clr_flag_B),
        .flag_A       (flag_A),
        .flag_B       (flag_B),
        .overflow_A   (overflow_A),
        .irq_n        (irq_n)
    );

    task automatic model_reset();
        m_cnt_a = 0; m_cnt_b = 0; m_zeros_b = 0;
        m_prev_a = 1'b0; m_prev_b = 1'b0;
        m_flag_a = 1'b0; m_flag_b = 1'b0; m_ovf_a = 1'b0; m_irqn = 1'b1;
    endtask

    task automatic model_step();
        logic set_a, set_b;
        set_a = 1'b0; set_b = 1'b0;
        if (rst) begin
            model_reset();
        end else if (clk_en) begin
            m_ovf_a = 1'b0;
            // Timer A: each running zero counts; past 1023 it reloads
            if (load_A && !m_prev_a) begin
                m_cnt_a = int'(value_A);
            end else if (load_A && zero) begin
                if (m_cnt_a == A_MAX) begin
                    m_cnt_a = int'(value_A);
                    m_ovf_a = 1'b1;
                    set_a   = enable_irq_A;
                end else begin
                    m_cnt_a = m_cnt_a + 1;
                end
            end
            m_prev_a = load_A;
            // Timer B: counts once every 16 running zeros since the load edge
            if (load_B && !m_prev_b) begin
                m_cnt_b   = int'(value_B);
                m_zeros_b = 0;
            end else if (load_B && zero) begin
                m_zeros_b = m_zeros_b + 1;
                if (m_zeros_b % B_DIV == 0) begin
                    if (m_cnt_b == B_MAX) begin
                        m_cnt_b = int'(value_B);
                        set_b   = enable_irq_B;
                    end else begin
                        m_cnt_b = m_cnt_b + 1;
                    end
                end
            end
            m_prev_b = load_B;
            m_flag_a = set_a ? 1'b1 : (clr_flag_A ? 1'b0 : m_flag_a);
            m_flag_b = set_b ? 1'b1 : (clr_flag_B ? 1'b0 : m_flag_b);
            m_irqn   = ~(m_flag_a | m_flag_b);
        end
    endtask

    // one clock: model follows the rising edge, expectation queued for monitor
    task automatic cyc();
        @(posedge clk);
        model_step();
        exp_q.push_back({m_flag_a, m_flag_b, m_ovf_a, m_irqn});
        @(negedge clk);
    endtask

    // n zeros, each preceded by gap-1 plain enabled cycles
    task automatic zeros(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            clk_en = 1'b1;
            zero = 1'b0;
            for (int j = 1; j < gap; j++) cyc();
            zero = 1'b1;
            cyc();
            zero = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        clk_en = 1'b1; zero = 1'b0;
        for (int i = 0; i < n; i++) cyc();
    endtask

    // Monitor: compare the DUT against the oldest queued expectation.
    always @(negedge clk) begin
        logic [3:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks = checks + 1;
            if ({flag_A, flag_B, overflow_A, irq_n} !== e) begin
                errors = errors + 1;
                $display("FAIL outputs t=%0t {flag_A,flag_B,overflow_A,irq_n} got=%b exp=%b",
                         $time, {flag_A, flag_B, overflow_A, irq_n}, e);
            end
        end
    end

    initial begin
        model_reset();
        // reset state
        for (int i = 0; i < 3; i++) cyc();
        rst = 1'b0;
        idle(3);

        // Timer A overflow on the 2nd zero with irq enabled
        enable_irq_A = 1'b1; value_A = 10'd1022; load_A = 1'b1;
        idle(1);
        zeros(3, 32);
        load_A = 1'b0; clr_flag_A = 1'b1; idle(1); clr_flag_A = 1'b0;

        // same with irq disabled: pulse but no flag
        enable_irq_A = 1'b0; load_A = 1'b1;
        idle(1);
        zeros(3, 32);
        load_A = 1'b0; idle(2);

        // Timer B with value 255: flag after 16 zeros, again after 32
        value_B = 8'd255; enable_irq_B = 1'b1; load_B = 1'b1;
        idle(1);
        zeros(15, 4);
        zeros(1, 4);
        clr_flag_B = 1'b1; idle(1); clr_flag_B = 1'b0;
        zeros(16, 4);
        load_B = 1'b0; clr_flag_B = 1'b1; idle(1); clr_flag_B = 1'b0;

        // set and clear in the same cycle: set wins, later clear drops it
        enable_irq_A = 1'b1; value_A = 10'd1023; load_A = 1'b1;
        idle(1);
        zeros(1, 3);
        clr_flag_A = 1'b1; zero = 1'b1; cyc(); zero = 1'b0; clr_flag_A = 1'b0;
        idle(2);
        clr_flag_A = 1'b1; idle(1); clr_flag_A = 1'b0;
        idle(2);
        load_A = 1'b0; idle(1);

        // clk_en low freezes overflow_A and everything else
        load_A = 1'b1; idle(1);
        zero = 1'b1; cyc(); zero = 1'b0;
        clk_en = 1'b0; zero = 1'b1;
        for (int i = 0; i < 4; i++) cyc();
        zero = 1'b0;
        idle(2);
        load_A = 1'b0; idle(1);

        // pause at 1020, restart from 1000 with no overflow in between
        value_A = 10'd1017; load_A = 1'b1; idle(1);
        zeros(3, 2);
        load_A = 1'b0;
        zeros(5, 2);
        value_A = 10'd1000; load_A = 1'b1; idle(1);
        zeros(30, 2);
        load_A = 1'b0; idle(2);

        // load edge coinciding with zero: no increment that cycle
        value_A = 10'd1022; zero = 1'b1; load_A = 1'b1; cyc(); zero = 1'b0;
        zeros(2, 2);
        load_A = 1'b0; idle(1);

        // asynchronous reset mid-prescale
        value_B = 8'd255; load_B = 1'b1; idle(1);
        zeros(9, 3);
        #3 rst = 1'b1;
        #1;
        checks = checks + 1;
        if ({flag_A, flag_B, overflow_A, irq_n} !== 4'b0001) begin
            errors = errors + 1;
            $display("FAIL async_reset got=%b exp=0001", {flag_A, flag_B, overflow_A, irq_n});
        end
        model_reset();
        cyc();
        #2 rst = 1'b0;
        @(negedge clk);
        load_B = 1'b0; idle(1);
        zeros(20, 2);
        load_B = 1'b1; idle(1);
        zeros(17, 2);

        // randomized traffic
        for (int i = 0; i < 6000; i++) begin
            clk_en = ($urandom_range(0, 7) != 0);
            zero   = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 99) == 0) load_A = ~load_A;
            if ($urandom_range(0, 149) == 0) load_B = ~load_B;
            if ($urandom_range(0, 29) == 0) value_A = 10'(A_MAX - $urandom_range(0, 12));
            if ($urandom_range(0, 29) == 0) value_B = 8'(B_MAX - $urandom_range(0, 3));
            if ($urandom_range(0, 49) == 0) enable_irq_A = ~enable_irq_A;
            if ($urandom_range(0, 49) == 0) enable_irq_B = ~enable_irq_B;
            clr_flag_A = ($urandom_range(0, 19) == 0);
            clr_flag_B = ($urandom_range(0, 19) == 0);
            cyc();
        end
        clr_flag_A = 1'b0; clr_flag_B = 1'b0;
        idle(2);

        @(negedge clk);
        #1;
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL queue_drain got=%0d exp=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
